// File: rtl/perf_pkg.sv
// Shared encodings for the performance monitor: FSM states and read-select constants.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned SEL_CYCLE = 0;

endpackage

// File: rtl/perf_monitor_if.sv
// Control, read-port and status bundle between the performance monitor and its host.
interface perf_monitor_if #(
  parameter int unsigned NUM_EVT = 4,
  parameter int unsigned CNT_W   = 32
);
  localparam int unsigned SEL_W = $clog2(NUM_EVT + 1);

  logic               start_i;
  logic               clear_i;
  logic               freeze_i;
  logic               snap_i;
  logic [NUM_EVT-1:0] evt_i;
  logic [SEL_W-1:0]   rd_sel_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic [NUM_EVT:0]   ovf_o;
  logic [CNT_W-1:0]   cycle_o;
  logic [1:0]         state_o;
  logic               done_o;

  modport master (
    output start_i, clear_i, freeze_i, snap_i, evt_i, rd_sel_i,
    input  rd_data_o, ovf_o, cycle_o, state_o, done_o
  );

  modport slave (
    input  start_i, clear_i, freeze_i, snap_i, evt_i, rd_sel_i,
    output rd_data_o, ovf_o, cycle_o, state_o, done_o
  );
endinterface

// File: rtl/perf_counter.sv
// Single event counter with sticky overflow; saturates or wraps depending on SATURATE.
module perf_counter #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clr) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (inc) begin
      if (&cnt_o) begin
        ovf_o <= 1'b1;
        cnt_o <= (SATURATE != 0) ? cnt_o : '0;
      end else begin
        cnt_o <= cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Cycle and event performance counters with run/freeze/done control,
// a snapshot shadow bank and a registered read port.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVT    = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 30,
  parameter int unsigned SATURATE   = 1
) (
  input  logic           clk,
  input  logic           rst,
  perf_monitor_if.slave  bus
);

  localparam int unsigned NCNT  = NUM_EVT + 1;
  localparam int unsigned SEL_W = $clog2(NUM_EVT + 1);

  state_e           state_q;
  state_e           state_d;
  logic             run;
  logic             last_cycle;
  logic [NCNT-1:0]  inc;
  logic [NCNT-1:0]  ovf;
  logic [CNT_W-1:0] cnt    [NCNT];
  logic [CNT_W-1:0] shadow [NCNT];
  logic [CNT_W-1:0] rd_d;
  logic [CNT_W-1:0] rd_q;

  // Counting is qualified purely by the registered state, so the deciding RUN cycle still counts.
  assign run = (state_q == ST_RUN);
  assign inc = {bus.evt_i & {NUM_EVT{run}}, run};

  assign last_cycle = (MAX_CYCLES != 0) &&
                      (({1'b0, cnt[SEL_CYCLE]} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (bus.start_i) state_d = ST_RUN;
        ST_RUN: begin
          if (last_cycle)        state_d = ST_DONE;
          else if (bus.freeze_i) state_d = ST_FROZEN;
        end
        ST_FROZEN: if (!bus.freeze_i) state_d = ST_RUN;
        ST_DONE:   state_d = ST_DONE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Index 0 is the cycle counter, index k is event k-1.
  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clear_i),
      .inc   (inc[g]),
      .cnt_o (cnt[g]),
      .ovf_o (ovf[g])
    );
  end

  // Shadows take the pre-increment values; clear overrides a simultaneous snap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCNT; k++) shadow[k] <= '0;
    end else if (bus.clear_i) begin
      for (int k = 0; k < NCNT; k++) shadow[k] <= '0;
    end else if (bus.snap_i) begin
      for (int k = 0; k < NCNT; k++) shadow[k] <= cnt[k];
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    rd_d = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (bus.rd_sel_i == SEL_W'(k)) rd_d = shadow[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else      rd_q <= rd_d;
  end

  assign bus.rd_data_o = rd_q;
  assign bus.ovf_o     = ovf;
  assign bus.cycle_o   = cnt[SEL_CYCLE];
  assign bus.state_o   = state_q;
  assign bus.done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: scoreboarded main instance plus 4-bit
// saturating and wrapping instances driven from a vector table.
module tb_perf_monitor;

  localparam int unsigned NE   = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned MAXC = 30;
  localparam int unsigned SW   = 4;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  perf_monitor_if #(.NUM_EVT(NE), .CNT_W(W))  bm ();
  perf_monitor_if #(.NUM_EVT(NE), .CNT_W(SW)) bs ();
  perf_monitor_if #(.NUM_EVT(NE), .CNT_W(SW)) bw ();

  perf_monitor #(.NUM_EVT(NE), .CNT_W(W), .MAX_CYCLES(MAXC), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .bus(bm));
  perf_monitor #(.NUM_EVT(NE), .CNT_W(SW), .MAX_CYCLES(0), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .bus(bs));
  perf_monitor #(.NUM_EVT(NE), .CNT_W(SW), .MAX_CYCLES(0), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .bus(bw));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model of the main instance
  typedef struct {
    logic [1:0]   st;
    logic [W-1:0] cyc;
    logic [W-1:0] rd;
    logic [NE:0]  ovf;
    logic         done;
  } exp_t;

  exp_t         sbq[$];
  logic [1:0]   m_state;
  logic [W-1:0] m_cnt [NE+1];
  logic [W-1:0] m_sh  [NE+1];
  logic [W-1:0] m_rd;
  logic [NE:0]  m_ovf;

  task automatic model_reset();
    m_state = 2'd0;
    m_rd    = '0;
    m_ovf   = '0;
    for (int k = 0; k <= NE; k++) begin
      m_cnt[k] = '0;
      m_sh[k]  = '0;
    end
  endtask

  task automatic bump(input int i);
    if (m_cnt[i] == {W{1'b1}}) m_ovf[i] = 1'b1;
    else                       m_cnt[i] = m_cnt[i] + W'(1);
  endtask

  task automatic step(input logic st, input logic cl, input logic fz, input logic sn,
                      input logic [NE-1:0] ev, input logic [2:0] sel);
    exp_t         e;
    exp_t         got;
    logic [W-1:0] rd_n;
    logic [1:0]   nxt;
    bm.start_i  = st;
    bm.clear_i  = cl;
    bm.freeze_i = fz;
    bm.snap_i   = sn;
    bm.evt_i    = ev;
    bm.rd_sel_i = sel;
    rd_n = '0;
    if (int'(sel) <= int'(NE)) rd_n = m_sh[sel];
    if (cl) begin
      m_state = 2'd0;
      m_ovf   = '0;
      for (int k = 0; k <= NE; k++) begin
        m_cnt[k] = '0;
        m_sh[k]  = '0;
      end
    end else begin
      if (sn) for (int k = 0; k <= NE; k++) m_sh[k] = m_cnt[k];
      if (m_state == 2'd1) begin
        if ((m_cnt[0] + W'(1)) == W'(MAXC)) nxt = 2'd3;
        else if (fz)                        nxt = 2'd2;
        else                                nxt = 2'd1;
        bump(0);
        for (int k = 0; k < NE; k++) if (ev[k]) bump(k + 1);
        m_state = nxt;
      end else if (m_state == 2'd0 && st) begin
        m_state = 2'd1;
      end else if (m_state == 2'd2 && !fz) begin
        m_state = 2'd1;
      end
    end
    m_rd   = rd_n;
    e.st   = m_state;
    e.cyc  = m_cnt[0];
    e.rd   = m_rd;
    e.ovf  = m_ovf;
    e.done = (m_state == 2'd3);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    check("sb_state", 64'(bm.state_o),   64'(got.st));
    check("sb_cycle", 64'(bm.cycle_o),   64'(got.cyc));
    check("sb_rd",    64'(bm.rd_data_o), 64'(got.rd));
    check("sb_ovf",   64'(bm.ovf_o),     64'(got.ovf));
    check("sb_done",  64'(bm.done_o),    64'(got.done));
  endtask

  task automatic step_small(input logic st, input logic fz, input logic sn,
                            input logic ev0, input logic [2:0] sel);
    bs.start_i = st;  bw.start_i = st;
    bs.clear_i = 1'b0; bw.clear_i = 1'b0;
    bs.freeze_i = fz; bw.freeze_i = fz;
    bs.snap_i = sn;   bw.snap_i = sn;
    bs.evt_i = {3'b000, ev0};
    bw.evt_i = {3'b000, ev0};
    bs.rd_sel_i = sel; bw.rd_sel_i = sel;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         n;
    logic [3:0] s_cnt;
    logic [4:0] s_ovf;
    logic [3:0] w_cnt;
    logic [4:0] w_ovf;
  } vec_t;

  vec_t vt [4];
  int   done_at;

  initial begin
    vt[0] = '{n: 5,  s_cnt: 4'd5,  s_ovf: 5'b00000, w_cnt: 4'd5,  w_ovf: 5'b00000};
    vt[1] = '{n: 10, s_cnt: 4'd15, s_ovf: 5'b00000, w_cnt: 4'd15, w_ovf: 5'b00000};
    vt[2] = '{n: 1,  s_cnt: 4'd15, s_ovf: 5'b00011, w_cnt: 4'd0,  w_ovf: 5'b00011};
    vt[3] = '{n: 4,  s_cnt: 4'd15, s_ovf: 5'b00011, w_cnt: 4'd4,  w_ovf: 5'b00011};

    rst = 1'b0;
    bm.start_i = 0; bm.clear_i = 0; bm.freeze_i = 0; bm.snap_i = 0; bm.evt_i = '0; bm.rd_sel_i = '0;
    bs.start_i = 0; bs.clear_i = 0; bs.freeze_i = 0; bs.snap_i = 0; bs.evt_i = '0; bs.rd_sel_i = '0;
    bw.start_i = 0; bw.clear_i = 0; bw.freeze_i = 0; bw.snap_i = 0; bw.evt_i = '0; bw.rd_sel_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 64'(bm.state_o), 64'd0);
    check("rst_cycle", 64'(bm.cycle_o), 64'd0);
    check("rst_rd",    64'(bm.rd_data_o), 64'd0);
    check("rst_ovf",   64'(bm.ovf_o), 64'd0);
    check("rst_done",  64'(bm.done_o), 64'd0);
    rst = 1'b1;

    // Budgeted run: evt0 constant, evt1 on even cycles
    for (int t = 0; t <= 44; t++) begin
      step(t >= 2, 1'b0, 1'b0, 1'b0, {2'b00, (t % 2 == 0), 1'b1}, 3'd0);
      if (t == 31) check("s1_not_done_yet", 64'(bm.done_o), 64'd0);
      if (t == 32) begin
        check("s1_done_rise", 64'(bm.done_o), 64'd1);
        check("s1_cycle_30",  64'(bm.cycle_o), 64'd30);
      end
    end
    check("s1_cycle_hold", 64'(bm.cycle_o), 64'd30);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd1);
    check("s1_cnt0", 64'(bm.rd_data_o), 64'd30);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd2);
    check("s1_cnt1", 64'(bm.rd_data_o), 64'd15);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0);
    check("s1_cyc_shadow", 64'(bm.rd_data_o), 64'd30);

    // Freeze for five cycles mid-run delays DONE by five cycles
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 3'd0);
    done_at = -1;
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      step(1'b0, 1'b0, (k >= 10 && k < 15), 1'b0, 4'hF, 3'd0);
      if (k == 10 || k == 14 || k == 15) check("s2_frozen_cycle", 64'(bm.cycle_o), 64'd10);
      if (k == 12) check("s2_frozen_state", 64'(bm.state_o), 64'd2);
      if (bm.done_o) done_at = k;
    end
    check("s2_done_at", 64'(done_at), 64'd35);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 3'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd4);
    check("s2_evt3", 64'(bm.rd_data_o), 64'd30);

    // Snapshot excludes the simultaneous event; read during snap returns old shadow
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 3'd0);
    for (int k = 1; k <= 18; k++) begin
      step(1'b0, 1'b0, 1'b0, (k == 10 || k == 16), 4'h1,
           (k >= 15 && k <= 17) ? 3'd1 : (k == 18) ? 3'd7 : 3'd0);
      if (k == 15) begin
        check("s4_snap9",   64'(bm.rd_data_o), 64'd9);
        check("s4_live15",  64'(bm.cycle_o),   64'd15);
      end
      if (k == 16) check("s4_old_shadow", 64'(bm.rd_data_o), 64'd9);
      if (k == 17) check("s4_new_shadow", 64'(bm.rd_data_o), 64'd15);
      if (k == 18) check("s4_sel_oob",    64'(bm.rd_data_o), 64'd0);
    end
    done_at = -1;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 3'd0);
      if (bm.done_o) done_at = k;
    end
    check("s4_reached_done", 64'(bm.done_o), 64'd1);

    // Clear beats start in DONE
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0);
    check("s5_idle",  64'(bm.state_o), 64'd0);
    check("s5_cycle", 64'(bm.cycle_o), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 3'd1);
    check("s5_run",        64'(bm.state_o),   64'd1);
    check("s5_shadow_clr", 64'(bm.rd_data_o), 64'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 3'd0);
    check("s5_count5", 64'(bm.cycle_o), 64'd5);

    // Asynchronous reset pulse mid-cycle
    bm.evt_i = '0;
    #2 rst = 1'b0;
    #1;
    check("s6_state", 64'(bm.state_o),   64'd0);
    check("s6_cycle", 64'(bm.cycle_o),   64'd0);
    check("s6_ovf",   64'(bm.ovf_o),     64'd0);
    check("s6_done",  64'(bm.done_o),    64'd0);
    #4 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("s6_still_idle", 64'(bm.state_o), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 3'd0);
    check("s6_restart", 64'(bm.cycle_o), 64'd3);

    // 4-bit saturate vs wrap, table-driven
    step_small(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < vt[r].n; i++) step_small(1'b0, (i == vt[r].n - 1), 1'b0, 1'b1, 3'd0);
      step_small(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      step_small(1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
      check("s3_sat_cnt",  64'(bs.rd_data_o), 64'(vt[r].s_cnt));
      check("s3_sat_cyc",  64'(bs.cycle_o),   64'(vt[r].s_cnt));
      check("s3_sat_ovf",  64'(bs.ovf_o),     64'(vt[r].s_ovf));
      check("s3_wrap_cnt", 64'(bw.rd_data_o), 64'(vt[r].w_cnt));
      check("s3_wrap_cyc", 64'(bw.cycle_o),   64'(vt[r].w_cnt));
      check("s3_wrap_ovf", 64'(bw.ovf_o),     64'(vt[r].w_ovf));
      step_small(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    end
    check("s3_unlimited", 64'(bs.done_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
